// File: rtl/hilbert_block_sequencer_pkg.sv
// Shared definitions for the Hilbert block sequencer and the FIR wrapper.
// Holds the sequencer FSM states and the default FIR pipeline latency.
package hilbert_block_sequencer_pkg;

    // Clock edges from a sample on the FIR input to its aligned Re/Im result.
    localparam int FIR_LATENCY_DEF = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        CLEAR  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/hilbert_block_sequencer_sample_fifo.sv
// Synchronous sample FIFO with a first-word-fall-through read port.
// Ports: clock, reset (sync, active high), push/data in, pop/q out,
//        count (0..DEPTH), full, empty. DEPTH must be a power of 2.
module sample_fifo
    import hilbert_block_sequencer_pkg::*;
#(
    parameter int width = 12,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [width-1:0]           data,
    output logic [width-1:0]           q,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] P_ONE = 1;
    localparam logic [AW:0]   C_ONE = 1;

    logic [width-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH.
            if (push) wr_ptr <= wr_ptr + P_ONE;
            if (pop)  rd_ptr <= rd_ptr + P_ONE;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + C_ONE;
                2'b01:   cnt <= cnt - C_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= data;
    end

    assign q     = mem[rd_ptr];
    assign count = cnt;
    // cnt never exceeds DEPTH, so its MSB alone marks full.
    assign full  = cnt[AW];
    assign empty = (cnt == '0);

endmodule

// File: rtl/hilbert_block_sequencer.sv
// Feeds the Hilbert FIR gap-free sample bursts from a bursty source,
// drains it with zeros, clears it, and tags its Re/Im outputs as valid.
// Ports: clock, reset; s_data/s_valid/s_ready source side; flush;
//        fir_reset/fir_in/fir_re/fir_im FIR side; m_re/m_im/m_valid out;
//        busy (not IDLE); overflow (sticky drop indicator).
module hilbert_block_sequencer
    import hilbert_block_sequencer_pkg::*;
#(
    parameter int total_bits  = 12,
    parameter int DEPTH       = 16,
    parameter int BLOCK_LEN   = 8,
    parameter int FIR_LATENCY = FIR_LATENCY_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [total_bits-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  flush,
    output logic                  fir_reset,
    output logic [total_bits-1:0] fir_in,
    input  logic [total_bits-1:0] fir_re,
    input  logic [total_bits-1:0] fir_im,
    output logic [total_bits-1:0] m_re,
    output logic [total_bits-1:0] m_im,
    output logic                  m_valid,
    output logic                  busy,
    output logic                  overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(FIR_LATENCY + 1);
    localparam logic [CW-1:0] C_ONE      = 1;
    localparam logic [CW-1:0] BLOCK_CNT  = CW'(BLOCK_LEN);
    localparam logic [DW-1:0] D_ONE      = 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(FIR_LATENCY - 1);

    seq_state_t              state;
    logic [CW-1:0]           count;
    logic                    full;
    logic                    empty;
    logic [total_bits-1:0]   head;
    logic                    push;
    logic                    pop;
    logic [DW-1:0]           drain_cnt;
    logic                    fir_tag;
    logic [FIR_LATENCY-1:0]  tag_sr;

    // Readiness comes from the registered count only.
    assign s_ready   = !full;
    assign push      = s_valid & s_ready;
    assign pop       = (state == STREAM) & !empty;
    assign busy      = (state != IDLE);
    assign fir_reset = reset | (state == CLEAR);

    sample_fifo #(
        .width (total_bits),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .data  (s_data),
        .q     (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (count >= BLOCK_CNT || (flush && !empty))
                        state <= STREAM;
                end
                STREAM: begin
                    // Last queued sample leaves with nothing arriving.
                    if (pop && count == C_ONE && !push) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LAST;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) state <= CLEAR;
                    else drain_cnt <= drain_cnt - D_ONE;
                end
                CLEAR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // fir_tag sits beside fir_in; the shift register then matches the
    // FIR's own pipeline so tag_sr's MSB lines up with fir_re/fir_im.
    always_ff @(posedge clock) begin
        if (reset) begin
            fir_in   <= '0;
            fir_tag  <= 1'b0;
            tag_sr   <= '0;
            m_valid  <= 1'b0;
            m_re     <= '0;
            m_im     <= '0;
            overflow <= 1'b0;
        end else begin
            fir_in  <= pop ? head : '0;
            fir_tag <= pop;
            tag_sr  <= {tag_sr[FIR_LATENCY-2:0], fir_tag};
            m_valid <= tag_sr[FIR_LATENCY-1];
            if (tag_sr[FIR_LATENCY-1]) begin
                m_re <= fir_re;
                m_im <= fir_im;
            end
            if (s_valid && !s_ready) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hilbert_block_sequencer.sv
// Randomized bench for hilbert_block_sequencer with a queue-based model
// and a behavioural FIR stand-in (pure delay on Re, masked delay on Im).
module tb_hilbert_block_sequencer;

    localparam int W       = 12;
    localparam int DEPTH   = 8;
    localparam int BLK     = 4;
    localparam int LAT     = 9;
    localparam int NCYC    = 4000;
    localparam int OFS     = LAT + 2;
    localparam logic [W-1:0] IM_MASK = 12'hA5A;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic         flush;
    logic         fir_reset;
    logic [W-1:0] fir_in;
    logic [W-1:0] fir_re;
    logic [W-1:0] fir_im;
    logic [W-1:0] m_re;
    logic [W-1:0] m_im;
    logic         m_valid;
    logic         busy;
    logic         overflow;

    always #5 clock = ~clock;

    hilbert_block_sequencer #(
        .total_bits  (W),
        .DEPTH       (DEPTH),
        .BLOCK_LEN   (BLK),
        .FIR_LATENCY (LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .flush     (flush),
        .fir_reset (fir_reset),
        .fir_in    (fir_in),
        .fir_re    (fir_re),
        .fir_im    (fir_im),
        .m_re      (m_re),
        .m_im      (m_im),
        .m_valid   (m_valid),
        .busy      (busy),
        .overflow  (overflow)
    );

    // FIR stand-in: result appears LAT edges after a sample is on fir_in.
    logic [W-1:0] pipe [LAT];
    always @(posedge clock) begin
        if (fir_reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= fir_in;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign fir_re = pipe[LAT-1];
    assign fir_im = pipe[LAT-1] ^ IM_MASK;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h want %0h",
                     tag, cyc, got, want);
        end
    endtask

    // Model state: queued samples, burst/quiet timing, expected outputs.
    logic [W-1:0] q [$];
    bit           stream_m;
    int           stream_age;
    int           idle_at;
    bit           ovf_m;
    logic [W-1:0] fir_exp;
    logic [W-1:0] re_last;
    logic [W-1:0] im_last;
    bit           exp_mv [NCYC+OFS+2];
    logic [W-1:0] exp_d  [NCYC+OFS+2];

    initial begin
        int rst_left;
        int pre;
        int mode;
        bit ready_m;
        bit vld;
        logic [W-1:0] d;
        logic [W-1:0] corner [5];

        corner[0] = 12'h7FF; corner[1] = 12'h800; corner[2] = 12'h001;
        corner[3] = 12'h000; corner[4] = 12'hFFF;
        reset = 1'b1; s_valid = 1'b0; s_data = '0; flush = 1'b0;
        stream_m = 0; stream_age = 0; idle_at = 0; ovf_m = 0;
        fir_exp = '0; re_last = '0; im_last = '0; rst_left = 0;
        repeat (3) @(posedge clock);

        for (cyc = 0; cyc < NCYC; cyc++) begin
            #1;
            mode = (cyc / 250) % 4;
            if (rst_left > 0) begin
                reset = 1'b1;
                rst_left--;
            end else if ($urandom_range(0, 499) == 0 ||
                         (stream_age == 4 && $urandom_range(0, 7) == 0)) begin
                reset = 1'b1;
                rst_left = $urandom_range(0, 2);
            end else begin
                reset = 1'b0;
            end
            case (mode)
                0: vld = ($urandom_range(0, 1) == 1);
                1: vld = ((cyc % 24) < 18);
                2: vld = ($urandom_range(0, 99) < 15);
                default: vld = ($urandom_range(0, 9) < 3);
            endcase
            s_valid = vld;
            if ($urandom_range(0, 7) == 0) s_data = corner[$urandom_range(0, 4)];
            else s_data = W'($urandom);
            flush = (mode == 3) ? ($urandom_range(0, 3) == 0)
                                : ($urandom_range(0, 31) == 0);

            @(negedge clock);
            if (exp_mv[cyc]) begin
                re_last = exp_d[cyc];
                im_last = exp_d[cyc] ^ IM_MASK;
            end
            expect_eq("s_ready", 32'(s_ready), 32'(q.size() < DEPTH));
            expect_eq("busy", 32'(busy), 32'(stream_m || cyc < idle_at));
            expect_eq("fir_reset", 32'(fir_reset),
                      32'(reset || (!stream_m && cyc == idle_at - 1)));
            expect_eq("fir_in", 32'(fir_in), 32'(fir_exp));
            expect_eq("m_valid", 32'(m_valid), 32'(exp_mv[cyc]));
            expect_eq("m_re", 32'(m_re), 32'(re_last));
            expect_eq("m_im", 32'(m_im), 32'(im_last));
            expect_eq("overflow", 32'(overflow), 32'(ovf_m));

            if (reset) begin
                q.delete();
                stream_m = 0; stream_age = 0; idle_at = 0; ovf_m = 0;
                fir_exp = '0; re_last = '0; im_last = '0;
                for (int k = cyc + 1; k <= cyc + OFS; k++) exp_mv[k] = 0;
            end else begin
                pre = q.size();
                ready_m = (pre < DEPTH);
                if (s_valid && !ready_m) ovf_m = 1;
                if (stream_m) begin
                    d = q.pop_front();
                    fir_exp = d;
                    exp_mv[cyc+OFS] = 1;
                    exp_d[cyc+OFS] = d;
                    stream_age++;
                end else begin
                    fir_exp = '0;
                end
                if (s_valid && ready_m) q.push_back(s_data);
                if (stream_m) begin
                    if (q.size() == 0) begin
                        stream_m = 0;
                        stream_age = 0;
                        idle_at = cyc + OFS;
                    end
                end else if (cyc >= idle_at &&
                             (pre >= BLK || (flush && pre > 0))) begin
                    stream_m = 1;
                end
            end
            @(posedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
